acc_bank: RTL and testbench

ACC_BANK -- requirements
Module: acc_bank

---
 rtl/acc_bank_pkg.sv | 17 +
 rtl/acc_lane.sv | 70 +++++++
 rtl/acc_bank.sv | 125 ++++++++++++
 tb/tb_acc_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/acc_bank_pkg.sv
// rtl/acc_bank_pkg.sv - shared types and default sizes for the accumulator bank
//
// Purpose : FSM state type and default parameter values used by acc_bank
//           and acc_lane.
// Contents: SHIFT_W_DEF, ACC_W_DEF, CHANNELS_DEF, state_e {IDLE, SHIFT}.
package acc_bank_pkg;

  localparam int unsigned SHIFT_W_DEF  = 32;
  localparam int unsigned ACC_W_DEF    = 128;
  localparam int unsigned CHANNELS_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/acc_lane.sv
// rtl/acc_lane.sv - one accumulator channel with sticky overflow
//
// Purpose : Holds one channel's accumulator. A clear zeroes the accumulator
//           and overflow flag. A commit adds the zero-extended frame value.
//           When both occur on the same edge, the clear is applied first, so
//           the result equals the frame value.
// Config  : ACC_BANK_SAT_EN defined   -> an overflowing add saturates to all-ones.
//           ACC_BANK_SAT_EN undefined -> an overflowing add wraps modulo 2^ACC_W.
//           In both cases ovf is set.
// Ports   : clk, rst       clock and synchronous active-high reset
//           clr_i          clear this lane at the next edge
//           add_en_i       commit add_val_i into this lane at the next edge
//           add_val_i      frame value (SHIFT_W bits)
//           acc_o          accumulator value
//           ovf_o          sticky overflow flag
module acc_lane import acc_bank_pkg::*; #(
  parameter int unsigned SHIFT_W = SHIFT_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               add_en_i,
  input  logic [SHIFT_W-1:0] add_val_i,
  output logic [ACC_W-1:0]   acc_o,
  output logic               ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] base;
  logic             base_ovf;
  logic [ACC_W:0]   sum;

  always_comb begin
    // Clear is applied before the add, so a clear and a commit on the same
    // edge leave exactly the committed frame value.
    base     = clr_i ? '0 : acc_q;
    base_ovf = clr_i ? 1'b0 : ovf_q;
    sum      = {1'b0, base} + {{(ACC_W - SHIFT_W + 1){1'b0}}, add_val_i};
    acc_d    = base;
    ovf_d    = base_ovf;
    if (add_en_i) begin
      if (sum[ACC_W]) begin
        ovf_d = 1'b1;
`ifdef ACC_BANK_SAT_EN
        acc_d = '1;
`else
        acc_d = sum[ACC_W-1:0];
`endif
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/acc_bank.sv
// rtl/acc_bank.sv - serial-frame accumulator bank with per-channel readout
//
// Purpose : Serial bits, MSB first, are shifted in while add is high. The
//           falling edge of add commits the frame into the channel that was
//           latched on the first bit. The bank holds CHANNELS lanes, and one
//           byte of one lane is read out through a register.
// Config  : ACC_BANK_SAT_EN selects saturate-on-overflow. The default is wrap.
// Ports   : clk, rst   clock and synchronous active-high reset
//           rx, add    serial data bit and frame-valid
//           ch         target channel, sampled on the first frame bit
//           clr        clear request for channel clr_ch
//           rd_ch, sel readout channel and byte index (0 = LSB byte)
//           data       registered readout byte (one-cycle latency)
//           busy       high while a frame is being shifted
//           ovf        sticky per-channel overflow flags
module acc_bank import acc_bank_pkg::*; #(
  parameter int unsigned SHIFT_W  = SHIFT_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  localparam int unsigned CH_W    = $clog2(CHANNELS),
  localparam int unsigned SEL_W   = $clog2(ACC_W / 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                add,
  input  logic [CH_W-1:0]     ch,
  input  logic                clr,
  input  logic [CH_W-1:0]     clr_ch,
  input  logic [CH_W-1:0]     rd_ch,
  input  logic [SEL_W-1:0]    sel,
  output logic [7:0]          data,
  output logic                busy,
  output logic [CHANNELS-1:0] ovf
);

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic [7:0]         data_q, data_d;
  logic               commit;
  logic [ACC_W-1:0]   acc [CHANNELS];
  logic [ACC_W-1:0]   rd_word;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (add)  state_d = SHIFT;
      SHIFT:   if (!add) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: a commit is the edge where add is seen low while shifting
  always_comb begin
    busy   = (state_q == SHIFT);
    commit = (state_q == SHIFT) && !add;
  end

  // Shift register and channel latch. The shift register is zero in IDLE,
  // so the first bit needs no special truncation.
  always_comb begin
    shift_d  = shift_q;
    cur_ch_d = cur_ch_q;
    if (add) begin
      shift_d = {shift_q[SHIFT_W-2:0], rx};
      if (state_q == IDLE) begin
        cur_ch_d = ch;
      end
    end else if (state_q == SHIFT) begin
      shift_d = '0;
    end
  end

  // Readout byte. The zero guard covers byte indices that lie past the top
  // of the accumulator.
  assign rd_word = acc[rd_ch];

  always_comb begin
    data_d = 8'h00;
    if (32'(sel) < (ACC_W / 8)) begin
      data_d = rd_word[8*sel +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      cur_ch_q <= '0;
      data_q   <= '0;
    end else begin
      shift_q  <= shift_d;
      cur_ch_q <= cur_ch_d;
      data_q   <= data_d;
    end
  end

  assign data = data_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    acc_lane #(
      .SHIFT_W (SHIFT_W),
      .ACC_W   (ACC_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (clr && (clr_ch == CH_W'(g))),
      .add_en_i  (commit && (cur_ch_q == CH_W'(g))),
      .add_val_i (shift_q),
      .acc_o     (acc[g]),
      .ovf_o     (ovf[g])
    );
  end

endmodule

// File: tb/tb_acc_bank.sv
// tb/tb_acc_bank.sv - scoreboard bench for acc_bank (32-bit lanes, 4 channels)
module tb_acc_bank;

  logic       clk = 1'b0;
  logic       rst, rx, add, clr;
  logic [1:0] ch, clr_ch, rd_ch, sel;
  logic [7:0] data;
  logic       busy;
  logic [3:0] ovf;

  logic       rd_req  = 1'b0;
  logic       rd_pend = 1'b0;
  int         n_checks = 0;
  int         n_fail   = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] o;
    logic       b;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

`ifdef ACC_BANK_SAT_EN
  localparam logic [7:0] OVF_LO = 8'hFF;
  localparam logic [7:0] OVF_HI = 8'hFF;
  localparam logic [7:0] STK_LO = 8'hFF;
`else
  localparam logic [7:0] OVF_LO = 8'h00;
  localparam logic [7:0] OVF_HI = 8'h00;
  localparam logic [7:0] STK_LO = 8'h02;
`endif

  always #5 clk = ~clk;

  acc_bank #(
    .SHIFT_W  (32),
    .ACC_W    (32),
    .CHANNELS (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .add    (add),
    .ch     (ch),
    .clr    (clr),
    .clr_ch (clr_ch),
    .rd_ch  (rd_ch),
    .sel    (sel),
    .data   (data),
    .busy   (busy),
    .ovf    (ovf)
  );

  always @(posedge clk) rd_pend <= rd_req;

  // Monitor: a request issued in one cycle is answered at the next edge.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got data=%02h with no expectation", data);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_checks += 3;
        if (data !== e.d) begin
          n_fail++;
          $display("FAIL %s data: got %02h expected %02h", nm, data, e.d);
        end
        if (ovf !== e.o) begin
          n_fail++;
          $display("FAIL %s ovf: got %04b expected %04b", nm, ovf, e.o);
        end
        if (busy !== e.b) begin
          n_fail++;
          $display("FAIL %s busy: got %0b expected %0b", nm, busy, e.b);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic req_set(input logic [1:0] c, input logic [1:0] s, input logic [7:0] d,
                         input logic [3:0] o, input logic b, input string nm);
    exp_t e;
    rd_ch  = c;
    sel    = s;
    rd_req = 1'b1;
    e.d = d;
    e.o = o;
    e.b = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic rd(input logic [1:0] c, input logic [1:0] s, input logic [7:0] d,
                    input logic [3:0] o, input string nm);
    step();
    req_set(c, s, d, o, 1'b0, nm);
  endtask

  // Shifts n bits MSB first. ch is toggled after the first bit, and that
  // change must be ignored. Returns in the commit cycle with add low.
  task automatic send_frame(input logic [1:0] c, input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step();
      add = 1'b1;
      rx  = bits[i];
      ch  = (i == n - 1) ? c : (c ^ 2'b01);
    end
    step();
    add = 1'b0;
    rx  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx = 1'b0; add = 1'b0; clr = 1'b0;
    ch = '0; clr_ch = '0; rd_ch = '0; sel = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    req_set(2'd0, 2'd0, 8'h00, 4'b0000, 1'b0, "rst_ch0");
    rd(2'd3, 2'd3, 8'h00, 4'b0000, "rst_ch3");

    // Frame A5 on ch1: the request in the commit cycle still sees the old value
    send_frame(2'd1, 64'hA5, 8);
    req_set(2'd1, 2'd0, 8'h00, 4'b0000, 1'b0, "a5_commit_edge");
    rd(2'd1, 2'd0, 8'hA5, 4'b0000, "a5_next");
    rd(2'd1, 2'd1, 8'h00, 4'b0000, "a5_byte1");

    // Back-to-back frames on ch2 with a single idle cycle between them
    send_frame(2'd2, 64'h10, 8);
    send_frame(2'd2, 64'h20, 8);
    req_set(2'd2, 2'd0, 8'h10, 4'b0000, 1'b0, "b2b_first");
    rd(2'd2, 2'd0, 8'h30, 4'b0000, "b2b_sum");
    rd(2'd0, 2'd0, 8'h00, 4'b0000, "b2b_ch0");
    rd(2'd3, 2'd0, 8'h00, 4'b0000, "b2b_ch3");

    // 40-bit frame: only the last 32 bits are kept
    send_frame(2'd0, 64'hAB_1234_5678, 40);
    rd(2'd0, 2'd0, 8'h78, 4'b0000, "long_b0");
    rd(2'd0, 2'd1, 8'h56, 4'b0000, "long_b1");
    rd(2'd0, 2'd2, 8'h34, 4'b0000, "long_b2");
    rd(2'd0, 2'd3, 8'h12, 4'b0000, "long_b3");

    // Preload ch3 to all-ones, then overflow it
    send_frame(2'd3, 64'hFFFF_FFFF, 32);
    rd(2'd3, 2'd3, 8'hFF, 4'b0000, "preload_b3");
    send_frame(2'd3, 64'h1, 1);
    rd(2'd3, 2'd0, OVF_LO, 4'b1000, "ovf_b0");
    rd(2'd3, 2'd3, OVF_HI, 4'b1000, "ovf_b3");
    send_frame(2'd3, 64'h02, 8);
    rd(2'd3, 2'd0, STK_LO, 4'b1000, "ovf_sticky");

    // Clear and commit on the same channel and the same edge
    send_frame(2'd1, 64'h07, 8);
    clr = 1'b1; clr_ch = 2'd1;
    rd(2'd1, 2'd0, 8'h07, 4'b1000, "clr_same_ch1");
    send_frame(2'd3, 64'h05, 8);
    clr = 1'b1; clr_ch = 2'd3;
    rd(2'd3, 2'd0, 8'h05, 4'b0000, "clr_same_ch3_b0");
    rd(2'd3, 2'd3, 8'h00, 4'b0000, "clr_same_ch3_b3");

    // Clear of a different channel on the commit edge
    send_frame(2'd2, 64'h01, 8);
    clr = 1'b1; clr_ch = 2'd0;
    rd(2'd0, 2'd0, 8'h00, 4'b0000, "clr_other_ch0_b0");
    rd(2'd0, 2'd3, 8'h00, 4'b0000, "clr_other_ch0_b3");
    rd(2'd2, 2'd0, 8'h31, 4'b0000, "clr_other_ch2");
    rd(2'd1, 2'd0, 8'h07, 4'b0000, "clr_other_ch1");

    // Reset in the middle of a frame
    for (int i = 0; i < 12; i++) begin
      step();
      add = 1'b1;
      rx  = 1'b1;
      ch  = 2'd2;
      if (i == 6) req_set(2'd2, 2'd0, 8'h31, 4'b0000, 1'b1, "midframe_busy");
    end
    step();
    rst = 1'b1;
    req_set(2'd2, 2'd0, 8'h00, 4'b0000, 1'b0, "rst_edge");
    step();
    rst = 1'b0;
    add = 1'b0;
    rx  = 1'b0;
    rd(2'd0, 2'd0, 8'h00, 4'b0000, "post_rst_ch0");
    rd(2'd1, 2'd0, 8'h00, 4'b0000, "post_rst_ch1");
    rd(2'd2, 2'd0, 8'h00, 4'b0000, "post_rst_ch2");
    rd(2'd2, 2'd1, 8'h00, 4'b0000, "post_rst_ch2_b1");
    rd(2'd3, 2'd0, 8'h00, 4'b0000, "post_rst_ch3");
    repeat (3) step();
    rd(2'd2, 2'd0, 8'h00, 4'b0000, "post_rst_idle_ch2");

    // Normal operation resumes after reset
    send_frame(2'd2, 64'h03, 8);
    rd(2'd2, 2'd0, 8'h03, 4'b0000, "resume_ch2");
    rd(2'd0, 2'd0, 8'h00, 4'b0000, "resume_ch0");

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    step();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
